encoded_stream_tx: RTL and testbench

Downstream stage of `matrixMultiply`. It captures the flat codeword vector `Encoded_MEM_flat` (64/K codewords of 8 bits each) in one valid/ready transfer. It then streams the codewords out one per cycle over a valid/ready byte interface, lowest codeword first. It tags the last codeword of each frame and counts completed frames, so the encoder's combinational output can feed a serial link or a FIFO.

---
 rtl/encoded_stream_tx.sv | 76 +++++++
 tb/tb_encoded_stream_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encoded_stream_tx.sv
// Serializes one captured codeword frame onto a valid/ready byte stream.
// Tags the last codeword of each frame and counts completed frames.
module encoded_stream_tx #(
    parameter int K  = 4,
    parameter int CW = 8,
    localparam int N  = 64 / K,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*CW-1:0] Encoded_MEM_flat,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_data,
    output logic [IW-1:0]   out_idx,
    output logic            out_last,
    output logic            busy,
    output logic [15:0]     frame_cnt
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state_q;
    logic [N*CW-1:0]   frame_q;
    logic [IW-1:0]     idx_q;
    logic [CW-1:0]     words [N];
    logic              at_last;
    logic              accept;
    logic              capture;

    for (genvar i = 0; i < N; i++) begin : g_words
        assign words[i] = frame_q[i*CW +: CW];
    end

    assign at_last   = (idx_q == IW'(N - 1));
    assign out_valid = (state_q == SEND);
    assign busy      = out_valid;
    assign out_idx   = idx_q;
    assign out_data  = words[idx_q];
    assign out_last  = out_valid && at_last;
    // Ready on the last accept so a new frame follows with no bubble.
    assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
    assign accept    = out_valid && out_ready;
    assign capture   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            idx_q     <= '0;
            frame_cnt <= '0;
        end else begin
            if (capture) begin
                frame_q <= Encoded_MEM_flat;
                idx_q   <= '0;
                state_q <= SEND;
            end else if (accept) begin
                if (at_last) begin
                    idx_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
            if (accept && at_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_encoded_stream_tx.sv
// Directed bench for encoded_stream_tx: scoreboarded K=4 stream plus
// a K=8 instance for the short-frame case.
module tb_encoded_stream_tx;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] i;
        logic       l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] flat;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic [15:0]  frame_cnt;

    logic         in_valid8;
    logic         in_ready8;
    logic [63:0]  flat8;
    logic         out_valid8;
    logic         out_ready8;
    logic [7:0]   out_data8;
    logic [2:0]   out_idx8;
    logic         out_last8;
    logic         busy8;
    logic [15:0]  frame_cnt8;

    exp_t         sbq[$];
    logic [15:0]  exp_cnt;
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_pop = 0;
    bit           cap;

    localparam logic [127:0] F1 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] F2 = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;

    always #5 clk = ~clk;

    encoded_stream_tx #(.K(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .Encoded_MEM_flat (flat),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_idx          (out_idx),
        .out_last         (out_last),
        .busy             (busy),
        .frame_cnt        (frame_cnt)
    );

    encoded_stream_tx #(.K(8)) dut8 (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid8),
        .in_ready         (in_ready8),
        .Encoded_MEM_flat (flat8),
        .out_valid        (out_valid8),
        .out_ready        (out_ready8),
        .out_data         (out_data8),
        .out_idx          (out_idx8),
        .out_last         (out_last8),
        .busy             (busy8),
        .frame_cnt        (frame_cnt8)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(logic [127:0] f);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.d = f[i*8 +: 8];
            e.i = 4'(i);
            e.l = (i == 15);
            sbq.push_back(e);
        end
    endtask

    // Inputs are driven before the call; outputs checked mid-cycle.
    task automatic tick();
        bit   exp_rdy;
        exp_t e;
        #1;
        chk("valid", 32'(out_valid), 32'(sbq.size() != 0));
        chk("busy", 32'(busy), 32'(sbq.size() != 0));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        exp_rdy = (sbq.size() == 0) || (sbq.size() == 1 && out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        cap = 1'b0;
        if (out_valid && sbq.size() > 0) begin
            e = sbq[0];
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_idx", 32'(out_idx), 32'(e.i));
            chk("out_last", 32'(out_last), 32'(e.l));
            if (out_ready) begin
                void'(sbq.pop_front());
                n_pop++;
                if (e.l) exp_cnt++;
            end
        end
        if (in_valid && exp_rdy) begin
            push(flat);
            cap = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int mode);
        int c;
        c = 0;
        while (sbq.size() > 0 && c < 400) begin
            out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            tick();
            c++;
        end
        chk("drain_done", 32'(sbq.size()), 32'd0);
        out_ready = 1'b1;
    endtask

    task automatic send(logic [127:0] f, int mode);
        flat     = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        flat     = '0;
        drain(mode);
        tick();
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_idx"}, 32'(out_idx), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        flat       = '0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        flat8      = '0;
        exp_cnt    = '0;
        #12;
        chk_reset_outs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(F1, 0);
        chk("cnt_after_f1", 32'(frame_cnt), 32'd1);

        send(F1, 1);
        chk("cnt_after_stall", 32'(frame_cnt), 32'd2);

        flat     = F1;
        in_valid = 1'b1;
        for (int c = 0; c < 40 && !cap; c++) tick();
        chk("b2b_cap1", 32'(cap), 32'd1);
        flat = F2;
        cap  = 1'b0;
        for (int c = 0; c < 40 && !cap; c++) tick();
        chk("b2b_cap2", 32'(cap), 32'd1);
        chk("b2b_cap_at_last", 32'(sbq.size()), 32'd16);
        in_valid = 1'b0;
        drain(0);
        tick();
        chk("cnt_after_b2b", 32'(frame_cnt), 32'd4);

        n_pop    = 0;
        flat     = F2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 40 && n_pop < 6; c++) tick();
        chk("pops_before_rst", 32'(n_pop), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        sbq.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        send(F1, 0);
        chk("cnt_after_rst", 32'(frame_cnt), 32'd1);

        force dut.frame_cnt = 16'hFFFE;
        #1;
        release dut.frame_cnt;
        exp_cnt = 16'hFFFE;
        send(F2, 0);
        chk("cnt_ffff", 32'(frame_cnt), 32'hFFFF);
        send(F1, 0);
        chk("cnt_wrap", 32'(frame_cnt), 32'h0000);

        flat8     = 64'h8877665544332211;
        in_valid8 = 1'b1;
        #1;
        chk("k8_in_ready", 32'(in_ready8), 32'd1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("k8_valid", 32'(out_valid8), 32'd1);
            chk("k8_data", 32'(out_data8), 32'(flat8[i*8 +: 8]));
            chk("k8_idx", 32'(out_idx8), 32'(i));
            chk("k8_last", 32'(out_last8), 32'(i == 7));
            @(posedge clk);
            #1;
        end
        chk("k8_idle", 32'(out_valid8), 32'd0);
        chk("k8_cnt", 32'(frame_cnt8), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
